// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core load/store
// path (port 0) and the loader/debug path (port 1). All outputs are registered.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access in progress; arbitrate between req0/req1
// ACCESS | memory signals driven from latched request; cnt counts down
// DONE   | result captured; done pulse is registered out of this state
module dmem_arbiter #(
  parameter int LATENCY = 1,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [2:0]    funct3_0,
  input  logic [31:0]   wdata0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [2:0]    funct3_1,
  input  logic [31:0]   wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic [2:0]    mem_funct3,
  output logic          mem_MemWrite,
  output logic          mem_MemRead,
  output logic [31:0]   mem_writeData,
  input  logic [31:0]   mem_readData
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          sel;
  logic          weLat;
  logic          winner;

  // On a tie the port that did not win last time goes next.
  assign winner = (req0 & req1) ? ~last : req1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      last          <= 1'b1;
      sel           <= 1'b0;
      weLat         <= 1'b0;
      gnt0          <= 1'b0;
      gnt1          <= 1'b0;
      done0         <= 1'b0;
      done1         <= 1'b0;
      rdata         <= '0;
      mem_addr      <= '0;
      mem_funct3    <= '0;
      mem_MemWrite  <= 1'b0;
      mem_MemRead   <= 1'b0;
      mem_writeData <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state <= ACCESS;
            sel   <= winner;
            last  <= winner;
            cnt   <= CW'(LATENCY - 1);
            if (winner) begin
              weLat         <= we1;
              mem_addr      <= addr1;
              mem_funct3    <= funct3_1;
              mem_writeData <= wdata1;
              mem_MemRead   <= ~we1;
              mem_MemWrite  <= we1 && (LATENCY == 1);
              gnt1          <= 1'b1;
            end else begin
              weLat         <= we0;
              mem_addr      <= addr0;
              mem_funct3    <= funct3_0;
              mem_writeData <= wdata0;
              mem_MemRead   <= ~we0;
              mem_MemWrite  <= we0 && (LATENCY == 1);
              gnt0          <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            state        <= DONE;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            if (!weLat) rdata <= mem_readData;
          end else begin
            cnt <= cnt - CW'(1);
            // Write enable is raised only for the final (cnt==0) cycle.
            if (cnt == CW'(1)) mem_MemWrite <= weLat;
          end
        end
        DONE: begin
          state <= IDLE;
          if (sel) done1 <= 1'b1;
          else     done0 <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (address, funct3, MemWrite, MemRead, writeData, readData) between two requesters: port 0 is the core load/store path, port 1 is the program loader / debug path.
- Uses round-robin arbitration with a req/gnt/done handshake.
- Latches each request and holds the memory signals stable for a configurable number of access cycles.
- Returns read data registered, with a one-cycle done pulse.

Parameters:
- LATENCY, 1, number of cycles memory signals are held per access (>=1)
- AW, 32, address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0  in  1  port 0 access request
- we0  in  1  port 0: 1=store, 0=load
- addr0  in  AW  port 0 byte address
- funct3_0  in  3  port 0 access size/sign code (memory encoding)
- wdata0  in  32  port 0 store data
- gnt0  out  1  port 0 request accepted (1-cycle pulse)
- done0  out  1  port 0 access complete (1-cycle pulse)
- req1, we1, addr1, funct3_1, wdata1, gnt1, done1  same as port 0 for port 1
- rdata  out  32  load result, valid when done0/done1 is high
- mem_addr  out  AW  to memory address
- mem_funct3  out  3  to memory funct3
- mem_MemWrite  out  1  to memory write enable
- mem_MemRead  out  1  to memory read enable
- mem_writeData  out  32  to memory write data
- mem_readData  in  32  from memory read data (combinational)

Behaviour:
- States:
  - IDLE: no access in progress.
  - ACCESS: memory signals driven from latched request; counter cnt runs LATENCY-1 down to 0.
  - DONE: result returned.
- Reset (rst high at posedge):
  - state=IDLE, cnt=0, last=1 (port 0 wins first tie).
  - All outputs 0: gnt*, done*, rdata, mem_*.
- rst mid-ACCESS/DONE: access is aborted; no done pulse; mem_MemWrite/mem_MemRead are 0 from the next cycle.
- IDLE:
  - If req0|req1, select a winner and go to ACCESS.
  - Only one requesting: that one wins.
  - Both requesting: winner = port != last.
- On grant:
  - Latch winner's we, addr, funct3, wdata; set sel=winner and last=winner; cnt=LATENCY-1.
  - gntN=1 for exactly the cycle after the sampling edge, i.e. the first ACCESS cycle.
- ACCESS:
  - mem_addr, mem_funct3 and mem_writeData come from the latched values and are stable for all LATENCY cycles.
  - Load: mem_MemRead=1 for all ACCESS cycles.
  - Store: mem_MemWrite=1 only in the cycle cnt==0 (exactly one write edge per store).
  - cnt decrements each cycle. When cnt==0, the next posedge captures rdata<=mem_readData (loads only; a store leaves rdata unchanged) and moves to DONE.
- DONE:
  - done[sel]=1 for one cycle; mem_* enables are 0; next state is IDLE.
- Timing:
  - Grant is seen one cycle after req is sampled in IDLE.
  - done arrives LATENCY+1 cycles after gnt.
  - Back-to-back accesses run every LATENCY+2 cycles.
- Handshake rules:
  - A requester holds req and its fields until it sees gnt.
  - Field changes after gnt are ignored.
  - req still high in DONE or ACCESS is not lost; it is evaluated at the next IDLE.
  - The non-granted requester keeps waiting with req high and wins the next arbitration (no starvation).
- Outputs are fully registered from state/latches: no combinational path from req* to mem_* or gnt*.
- mem_addr, mem_funct3, mem_writeData keep their last value in IDLE/DONE. Only the enables are forced to 0.

Test Plan:
- Reset, LATENCY=1: hold rst 2 cycles with req0=1 -> all outputs 0. After release, gnt0 pulses on the 1st cycle and done0 on the 3rd.
- Port 0 store then load, LATENCY=1: store addr 0x10, wdata 0xDEADBEEF, funct3=010 -> exactly one cycle of mem_MemWrite=1 with mem_addr=0x10. Then load 0x10 -> rdata=0xDEADBEEF with done0.
- Simultaneous req0=req1=1 held continuously -> grants alternate 0,1,0,1. Each done goes to the matching port. No two gnts within LATENCY+2 cycles.
- LATENCY=3, port 1 load -> mem_MemRead high for 3 cycles with constant mem_addr. Changing addr1 after gnt1 has no effect. done1 arrives 4 cycles after gnt1.
- rst asserted during the 2nd ACCESS cycle of a store (LATENCY=3) -> mem_MemWrite never 1 and no done. The next req1 is served normally.
- req0 held through DONE with req1 idle -> a new gnt0 occurs on the cycle after DONE returns to IDLE. No request is dropped.
